// File: rtl/tx_frame_send.sv
// Serialises the four 16-bit 2x2-inverse results as a byte frame (header, 8 data bytes,
// optional checksum) on a valid/ready stream. Define TX_CHECKSUM_EN to append the checksum byte.
module tx_frame_send #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         GAP_CYCLES = 4
) (
  input  logic        I_sys_clk,
  input  logic        I_sys_rst,
  input  logic [15:0] b11,
  input  logic [15:0] b12,
  input  logic [15:0] b21,
  input  logic [15:0] b22,
  input  logic        load_valid,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
`ifdef TX_CHECKSUM_EN
    CSUM,
`endif
    GAP
  } state_t;

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t      state;
  logic [63:0] words;
  logic [2:0]  idx;
  logic [7:0]  gap_cnt;
`ifdef TX_CHECKSUM_EN
  logic [7:0]  acc;
`endif

  // Byte i of the latched words, most significant byte of b11 first.
  function automatic logic [7:0] pick_byte(input logic [63:0] w, input logic [2:0] i);
    return w[{~i, 3'b111} -: 8];
  endfunction

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) begin
      state      <= IDLE;
      words      <= 64'd0;
      idx        <= 3'd0;
      gap_cnt    <= 8'd0;
`ifdef TX_CHECKSUM_EN
      acc        <= 8'd0;
`endif
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            words    <= {b11, b12, b21, b22};
            idx      <= 3'd0;
`ifdef TX_CHECKSUM_EN
            acc      <= 8'd0;
`endif
            state    <= HDR;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            tx_valid <= 1'b1;
            tx_data  <= HEADER;
          end
        end
        HDR: begin
          if (tx_ready) begin
            state   <= DATA;
            idx     <= 3'd0;
            tx_data <= pick_byte(words, 3'd0);
          end
        end
        DATA: begin
          if (tx_ready) begin
`ifdef TX_CHECKSUM_EN
            acc <= acc + tx_data;
`endif
            if (idx == 3'd7) begin
`ifdef TX_CHECKSUM_EN
              state   <= CSUM;
              tx_data <= acc + tx_data;
`else
              // Last byte accepted: with no gap the block is ready again immediately.
              tx_valid   <= 1'b0;
              frame_done <= 1'b1;
              gap_cnt    <= 8'd0;
              if (GAP_CYCLES == 0) begin
                state    <= IDLE;
                busy     <= 1'b0;
                in_ready <= 1'b1;
              end else begin
                state <= GAP;
              end
`endif
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= pick_byte(words, idx + 3'd1);
            end
          end
        end
`ifdef TX_CHECKSUM_EN
        CSUM: begin
          if (tx_ready) begin
            tx_valid   <= 1'b0;
            frame_done <= 1'b1;
            gap_cnt    <= 8'd0;
            if (GAP_CYCLES == 0) begin
              state    <= IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
`endif
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_send.sv
// Bench for tx_frame_send: byte-queue reference model checked every cycle plus directed
// literal frame checks; a second instance with GAP_CYCLES=0 covers back-to-back loading.
module tb_tx_frame_send;

  localparam int GAP = 4;
`ifdef TX_CHECKSUM_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] b11, b12, b21, b22;
  logic        load_valid, tx_ready;
  logic        in_ready, tx_valid, frame_done, busy;
  logic [7:0]  tx_data;
  logic        ld0, rdy0;
  logic        in_ready0, tx_valid0, frame_done0, busy0;
  logic [7:0]  tx_data0;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  logic [7:0]  m_q[$];
  bit          m_idle = 1'b1;
  int          m_gap = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_w;
  logic [7:0]  m_sum;
  logic [7:0]  m_b;
  logic [7:0]  got_q[$];

  tx_frame_send #(.HEADER(8'hA5), .GAP_CYCLES(GAP)) u_dut (
    .I_sys_clk(clk), .I_sys_rst(rst),
    .b11(b11), .b12(b12), .b21(b21), .b22(b22),
    .load_valid(load_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_done(frame_done), .busy(busy)
  );

  tx_frame_send #(.HEADER(8'hA5), .GAP_CYCLES(0)) u_dut0 (
    .I_sys_clk(clk), .I_sys_rst(rst),
    .b11(b11), .b12(b12), .b21(b21), .b22(b22),
    .load_valid(ld0), .in_ready(in_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(rdy0),
    .frame_done(frame_done0), .busy(busy0)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of bytes still to be sent, followed by a gap countdown.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_idle = 1'b1;
      m_gap  = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_idle) begin
        if (load_valid) begin
          m_w   = {b11, b12, b21, b22};
          m_sum = 8'd0;
          m_q.delete();
          m_q.push_back(8'hA5);
          for (int i = 0; i < 8; i++) begin
            m_b = m_w[63 - 8*i -: 8];
            m_q.push_back(m_b);
            m_sum = m_sum + m_b;
          end
`ifdef TX_CHECKSUM_EN
          m_q.push_back(m_sum);
`endif
          m_idle = 1'b0;
        end
      end else if (m_q.size() > 0) begin
        if (tx_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_done = 1'b1;
            if (GAP == 0) m_idle = 1'b1;
            else m_gap = GAP;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) m_idle = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("in_ready", 32'(in_ready), 32'(m_idle));
      checkOutput("busy", 32'(busy), 32'(!m_idle));
      checkOutput("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
      checkOutput("frame_done", 32'(frame_done), 32'(m_done));
      if (m_q.size() > 0) checkOutput("tx_data", 32'(tx_data), 32'(m_q[0]));
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
    end
  end

  task applyStimulus(input logic [15:0] v11, input logic [15:0] v12,
                     input logic [15:0] v21, input logic [15:0] v22);
    int k;
    k = 0;
    while (!in_ready && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    b11 = v11; b12 = v12; b21 = v21; b22 = v22;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task waitFrameDone(input int max);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      @(negedge clk);
      seen = frame_done;
    end
    if (!seen) checkOutput("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task waitByte(input logic [7:0] val);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      seen = tx_valid && (tx_data == val);
    end
    if (!seen) checkOutput("byte_wait_timeout", 32'(tx_data), 32'(val));
  endtask

  task checkFrame(input logic [79:0] exp_bytes);
    logic [79:0] v;
    v = exp_bytes;
    checkOutput("frame_len", got_q.size(), FLEN);
    for (int i = 0; i < FLEN; i++)
      checkOutput("frame_byte", (got_q.size() > i) ? 32'(got_q[i]) : 32'hDEAD,
                  32'(v[79 - 8*i -: 8]));
    got_q.delete();
  endtask

  initial begin
    int cnt;
    logic [79:0] exp0;
    rst = 1'b1; load_valid = 1'b0; tx_ready = 1'b1; ld0 = 1'b0; rdy0 = 1'b1;
    b11 = 16'h0; b12 = 16'h0; b21 = 16'h0; b22 = 16'h0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] basic frame");
    applyStimulus(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    waitFrameDone(40);
    checkFrame(80'hA5_1234_5678_9ABC_DEF0_38);
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("gap_len", cnt, GAP);

    $display("[TB] backpressure on byte 56");
    applyStimulus(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    waitByte(8'h56);
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_hold_data", 32'(tx_data), 32'h56);
      checkOutput("bp_hold_valid", 32'(tx_valid), 32'd1);
      @(posedge clk);
    end
    #1 tx_ready = 1'b1;
    waitFrameDone(40);
    checkFrame(80'hA5_1234_5678_9ABC_DEF0_38);

    $display("[TB] checksum wrap and zeros");
    applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    waitFrameDone(40);
    checkFrame(80'hA5_FFFF_FFFF_FFFF_FFFF_F8);
    applyStimulus(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    waitFrameDone(40);
    checkFrame(80'hA5_0000_0000_0000_0000_00);

    $display("[TB] load while busy");
    applyStimulus(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    repeat (3) begin @(posedge clk); #1; end
    b11 = 16'h1111; b12 = 16'h2222; b21 = 16'h3333; b22 = 16'h4444;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    b11 = 16'h0; b12 = 16'h0; b21 = 16'h0; b22 = 16'h0;
    waitFrameDone(40);
    checkFrame(80'hA5_1234_5678_9ABC_DEF0_38);
    applyStimulus(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    waitFrameDone(40);
    checkFrame(80'hA5_1111_2222_3333_4444_54);

    $display("[TB] reset mid-frame");
    applyStimulus(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    waitByte(8'h9A);
    rst = 1'b1;
    load_valid = 1'b1;
    b11 = 16'hFFFF;
    @(posedge clk); #1;
    rst = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    checkOutput("rst_beats_load", 32'(in_ready), 32'd1);
    got_q.delete();
    applyStimulus(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    waitFrameDone(40);
    checkFrame(80'hA5_1234_5678_9ABC_DEF0_38);

    $display("[TB] zero gap, back-to-back load");
    exp0 = 80'hA5_1234_5678_9ABC_DEF0_38;
    @(posedge clk); #1;
    checkOutput("g0_idle_ready", 32'(in_ready0), 32'd1);
    b11 = 16'h1234; b12 = 16'h5678; b21 = 16'h9ABC; b22 = 16'hDEF0;
    ld0 = 1'b1;
    for (int k = 1; k <= FLEN + 2; k++) begin
      @(posedge clk); #1;
      ld0 = (k == FLEN + 1);
      @(negedge clk);
      if (k <= FLEN) begin
        checkOutput("g0_valid", 32'(tx_valid0), 32'd1);
        checkOutput("g0_byte", 32'(tx_data0), 32'(exp0[79 - 8*(k-1) -: 8]));
        checkOutput("g0_no_done", 32'(frame_done0), 32'd0);
      end else if (k == FLEN + 1) begin
        checkOutput("g0_done", 32'(frame_done0), 32'd1);
        checkOutput("g0_ready", 32'(in_ready0), 32'd1);
        checkOutput("g0_idle_valid", 32'(tx_valid0), 32'd0);
      end else begin
        checkOutput("g0_b2b_valid", 32'(tx_valid0), 32'd1);
        checkOutput("g0_b2b_hdr", 32'(tx_data0), 32'hA5);
        checkOutput("g0_b2b_busy", 32'(busy0), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
